// File: rtl/mips_loader_defs_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM state encodings and stream framing constants.
package mips_loader_defs;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word shift register with a wrapping byte counter.
// word_next is the word as it will look once byte_in is shifted in.
module byte_packer
    import mips_loader_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    assign word_next = {word_q[23:0], byte_in};
    assign word_full = shift_en && !clr && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr) begin
            cnt_d  = 2'd0;
            word_d = 32'd0;
        end else if (shift_en) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = word_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes big-endian words
// into instruction memory from word 0, then releases the core via cpu_run.
module imem_loader
    import mips_loader_defs::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W+1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic              byte_ready_q, byte_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W+1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_run_q, cpu_run_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic        xfer;
    logic [15:0] len_full;
    logic [31:0] word_next;
    logic        word_full;

    assign xfer = byte_valid && byte_ready_q;

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state_q == IDLE),
        .shift_en  (xfer && (state_q == DATA)),
        .byte_in   (byte_data),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        len_full     = {len_q[15:8], byte_data};
        case (state_q)
            IDLE:   if (start) state_d = LEN_HI;
            LEN_HI: if (xfer) begin
                len_d[15:8] = byte_data;
                state_d     = LEN_LO;
            end
            LEN_LO: if (xfer) begin
                len_d[7:0] = byte_data;
                // DEPTH itself is a legal length; only strictly larger is rejected
                if (len_full == 16'd0)                        state_d = DONE;
                else if ({16'd0, len_full} > 32'(DEPTH))      state_d = ERROR;
                else                                          state_d = DATA;
            end
            DATA:   if (word_full) begin
                state_d      = WRITE;
                imem_wdata_d = word_next;
                imem_addr_d  = {idx_q[ADDR_W-1:0], 2'b00};
            end
            WRITE: begin
                idx_d   = idx_q + 1'b1;
                state_d = (16'(idx_q) + 16'd1 == len_q) ? DONE : DATA;
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
        byte_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA);
        imem_we_d    = (state_d == WRITE);
        cpu_run_d    = (state_d == DONE);
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= 16'd0;
            idx_q        <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            cpu_run_q    <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            byte_ready_q <= byte_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_run_q    <= cpu_run_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_run    = cpu_run_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a default-depth instance and a 4-word instance
// share clock and reset; expected writes are queued as bytes are driven.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 0, bv_a = 0;
    logic [7:0] bd_a = 0;
    logic       br_a, we_a, run_a, done_a, err_a;
    logic [9:0] addr_a;
    logic [31:0] wd_a;

    logic       start_b = 0, bv_b = 0;
    logic [7:0] bd_b = 0;
    logic       br_b, we_b, run_b, done_b, err_b;
    logic [3:0] addr_b;
    logic [31:0] wd_b;

    imem_loader #(.ADDR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .byte_valid(bv_a), .byte_data(bd_a),
        .byte_ready(br_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
        .cpu_run(run_a), .done(done_a), .error(err_a)
    );

    imem_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .byte_valid(bv_b), .byte_data(bd_b),
        .byte_ready(br_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
        .cpu_run(run_b), .done(done_b), .error(err_b)
    );

    int asserts = 0;
    int fails   = 0;
    int wr_cnt_a = 0;
    int wr_cnt_b = 0;
    logic [41:0] exp_a[$];
    logic [35:0] exp_b[$];

    // Write monitors: every strobe must match the head of its scoreboard
    always @(negedge clk) begin
        logic [41:0] ea;
        logic [35:0] eb;
        if (we_a === 1'b1) begin
            wr_cnt_a++;
            asserts++;
            if (exp_a.size() == 0) begin
                fails++;
                $display("FAIL write_a_unexpected: got addr=%h data=%h, none expected", addr_a, wd_a);
            end else begin
                ea = exp_a.pop_front();
                if ({addr_a, wd_a} !== ea) begin
                    fails++;
                    $display("FAIL write_a: got addr=%h data=%h, expected addr=%h data=%h",
                             addr_a, wd_a, ea[41:32], ea[31:0]);
                end
            end
        end
        if (we_b === 1'b1) begin
            wr_cnt_b++;
            asserts++;
            if (exp_b.size() == 0) begin
                fails++;
                $display("FAIL write_b_unexpected: got addr=%h data=%h, none expected", addr_b, wd_b);
            end else begin
                eb = exp_b.pop_front();
                if ({addr_b, wd_b} !== eb) begin
                    fails++;
                    $display("FAIL write_b: got addr=%h data=%h, expected addr=%h data=%h",
                             addr_b, wd_b, eb[35:32], eb[31:0]);
                end
            end
        end
    end

    task automatic send_byte(input bit b, input logic [7:0] d);
        bit ok = 0;
        if (b) begin bv_b = 1; bd_b = d; end
        else   begin bv_a = 1; bd_a = d; end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if ((b ? br_b : br_a) === 1'b1) begin
                ok = 1;
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            asserts++;
            fails++;
            $display("FAIL send_byte_timeout: byte %h not accepted within 50 cycles", d);
        end
    endtask

    task automatic idle_inputs();
        bv_a = 0; bv_b = 0; start_a = 0; start_b = 0;
    endtask

    task automatic pulse_start(input bit b);
        @(posedge clk); #1;
        if (b) start_b = 1; else start_a = 1;
        @(posedge clk); #1;
        start_a = 0; start_b = 0;
    endtask

    task automatic check_queues_empty(input string name);
        asserts++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            fails++;
            $display("FAIL %s_pending: got %0d/%0d writes outstanding, expected 0/0",
                     name, exp_a.size(), exp_b.size());
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        asserts++;
        if ({br_a, we_a, addr_a, wd_a, run_a, done_a, err_a} !== 47'd0) begin
            fails++;
            $display("FAIL reset_a: got rdy=%b we=%b addr=%h data=%h run=%b done=%b err=%b, expected all 0",
                     br_a, we_a, addr_a, wd_a, run_a, done_a, err_a);
        end
        asserts++;
        if ({br_b, we_b, addr_b, wd_b, run_b, done_b, err_b} !== 41'd0) begin
            fails++;
            $display("FAIL reset_b: got rdy=%b we=%b addr=%h data=%h run=%b done=%b err=%b, expected all 0",
                     br_b, we_b, addr_b, wd_b, run_b, done_b, err_b);
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_two_words();
        logic [7:0] s[10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        test_reset();
        exp_a.push_back({10'h000, 32'h20080005});
        exp_a.push_back({10'h004, 32'hAC080000});
        pulse_start(0);
        foreach (s[i]) send_byte(0, s[i]);
        bv_a = 0;
        @(negedge clk);
        asserts++;
        if (we_a !== 1'b1 || br_a !== 1'b0 || run_a !== 1'b0) begin
            fails++;
            $display("FAIL two_words_final_write: got we=%b rdy=%b run=%b, expected 1 0 0", we_a, br_a, run_a);
        end
        @(negedge clk);
        asserts++;
        if (done_a !== 1'b1 || run_a !== 1'b1 || we_a !== 1'b0 || br_a !== 1'b0) begin
            fails++;
            $display("FAIL two_words_done: got done=%b run=%b we=%b rdy=%b, expected 1 1 0 0",
                     done_a, run_a, we_a, br_a);
        end
        check_queues_empty("two_words");
    endtask

    task automatic test_zero_len();
        int w0;
        test_reset();
        w0 = wr_cnt_a;
        pulse_start(0);
        send_byte(0, 8'h00);
        send_byte(0, 8'h00);
        bv_a = 0;
        repeat (3) @(negedge clk);
        asserts++;
        if (done_a !== 1'b1 || run_a !== 1'b1 || err_a !== 1'b0 || wr_cnt_a != w0) begin
            fails++;
            $display("FAIL zero_len: got done=%b run=%b err=%b writes=%0d, expected 1 1 0 0",
                     done_a, run_a, err_a, wr_cnt_a - w0);
        end
    endtask

    task automatic test_too_long();
        int w0;
        test_reset();
        w0 = wr_cnt_a;
        pulse_start(0);
        send_byte(0, 8'h01);
        send_byte(0, 8'h01);
        bv_a = 1; bd_a = 8'h77;
        @(negedge clk);
        asserts++;
        if (err_a !== 1'b1 || br_a !== 1'b0 || done_a !== 1'b0 || run_a !== 1'b0) begin
            fails++;
            $display("FAIL too_long: got err=%b rdy=%b done=%b run=%b, expected 1 0 0 0",
                     err_a, br_a, done_a, run_a);
        end
        pulse_start(0);
        repeat (4) @(negedge clk);
        bv_a = 0;
        asserts++;
        if (err_a !== 1'b1 || br_a !== 1'b0 || done_a !== 1'b0 || wr_cnt_a != w0) begin
            fails++;
            $display("FAIL too_long_start_ignored: got err=%b rdy=%b done=%b writes=%0d, expected 1 0 0 0",
                     err_a, br_a, done_a, wr_cnt_a - w0);
        end
    endtask

    task automatic test_random_valid();
        logic [7:0] s[6] = '{8'h00, 8'h01, 8'h8C, 8'h49, 8'h00, 8'h1F};
        int w0;
        test_reset();
        w0 = wr_cnt_a;
        exp_a.push_back({10'h000, 32'h8C49001F});
        // A byte offered alongside start must not be taken in IDLE
        bv_a = 1; bd_a = 8'hFF;
        pulse_start(0);
        foreach (s[i]) begin
            bv_a = 0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_byte(0, s[i]);
        end
        bv_a = 1; bd_a = 8'hEE;
        @(negedge clk);
        asserts++;
        if (we_a !== 1'b1 || br_a !== 1'b0) begin
            fails++;
            $display("FAIL random_valid_write_stall: got we=%b rdy=%b, expected 1 0", we_a, br_a);
        end
        repeat (3) @(negedge clk);
        bv_a = 0;
        asserts++;
        if (wr_cnt_a - w0 != 1 || done_a !== 1'b1) begin
            fails++;
            $display("FAIL random_valid_count: got writes=%0d done=%b, expected 1 1", wr_cnt_a - w0, done_a);
        end
        check_queues_empty("random_valid");
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] s1[8] = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [7:0] s2[6] = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        test_reset();
        exp_a.push_back({10'h000, 32'h11223344});
        pulse_start(0);
        foreach (s1[i]) send_byte(0, s1[i]);
        #2 rst_n = 0;
        #1;
        asserts++;
        if ({br_a, we_a, addr_a, wd_a, run_a, done_a, err_a} !== 47'd0) begin
            fails++;
            $display("FAIL reset_mid_load: got rdy=%b we=%b addr=%h data=%h run=%b done=%b err=%b, expected all 0",
                     br_a, we_a, addr_a, wd_a, run_a, done_a, err_a);
        end
        bv_a = 0;
        @(posedge clk); #1;
        rst_n = 1;
        exp_a.push_back({10'h000, 32'hDEADBEEF});
        pulse_start(0);
        foreach (s2[i]) send_byte(0, s2[i]);
        bv_a = 0;
        repeat (2) @(negedge clk);
        asserts++;
        if (done_a !== 1'b1 || run_a !== 1'b1) begin
            fails++;
            $display("FAIL reset_reload_done: got done=%b run=%b, expected 1 1", done_a, run_a);
        end
        check_queues_empty("reset_mid_load");
    endtask

    task automatic test_full_depth();
        logic [7:0]  k;
        logic [31:0] w;
        test_reset();
        pulse_start(0);
        send_byte(0, 8'h01);
        send_byte(0, 8'h00);
        for (int i = 0; i < 256; i++) begin
            k = 8'(i);
            w = {k, ~k, 8'h5A, k ^ 8'hC3};
            exp_a.push_back({8'(i), 2'b00, w});
            for (int j = 3; j >= 0; j--) send_byte(0, w[j*8 +: 8]);
        end
        bv_a = 0;
        repeat (2) @(negedge clk);
        asserts++;
        if (done_a !== 1'b1 || err_a !== 1'b0 || addr_a !== 10'h3FC) begin
            fails++;
            $display("FAIL full_depth: got done=%b err=%b last_addr=%h, expected 1 0 3fc", done_a, err_a, addr_a);
        end
        check_queues_empty("full_depth");
    endtask

    task automatic test_small_mem();
        logic [31:0] w;
        int w0;
        test_reset();
        w0 = wr_cnt_b;
        pulse_start(1);
        send_byte(1, 8'h00);
        send_byte(1, 8'h04);
        for (int i = 0; i < 4; i++) begin
            w = 32'hA5000000 | 32'(i * 32'h00010203);
            exp_b.push_back({2'(i), 2'b00, w});
            for (int j = 3; j >= 0; j--) send_byte(1, w[j*8 +: 8]);
        end
        bv_b = 0;
        repeat (2) @(negedge clk);
        asserts++;
        if (done_b !== 1'b1 || run_b !== 1'b1 || err_b !== 1'b0 || wr_cnt_b - w0 != 4) begin
            fails++;
            $display("FAIL small_mem_done: got done=%b run=%b err=%b writes=%0d, expected 1 1 0 4",
                     done_b, run_b, err_b, wr_cnt_b - w0);
        end
        check_queues_empty("small_mem");
        test_reset();
        pulse_start(1);
        send_byte(1, 8'h00);
        send_byte(1, 8'h05);
        bv_b = 0;
        @(negedge clk);
        asserts++;
        if (err_b !== 1'b1 || br_b !== 1'b0 || wr_cnt_b - w0 != 4) begin
            fails++;
            $display("FAIL small_mem_too_long: got err=%b rdy=%b writes=%0d, expected 1 0 4",
                     err_b, br_b, wr_cnt_b - w0);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_len();
        test_too_long();
        test_random_valid();
        test_reset_mid_load();
        test_full_depth();
        test_small_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
